// File: rtl/irq_bus_scheduler_if.sv
// irq_bus_scheduler_if
//   Bundles the request/grant signals of irq_bus_scheduler.
//   master : request source / grant consumer (drives en, req_*, irq_ack)
//   slave  : the scheduler (drives irq_valid, irq_bus, irq_chan, pend_*, timeout_err)
//   en          channel enable shared by all buses
//   req_a/b/c   request pulses, one bit per channel
//   irq_ack     consumer accepts the current grant
//   irq_valid   grant presented
//   irq_bus     granted bus (0=A 1=B 2=C)
//   irq_chan    granted channel index
//   pend_a/b/c  raw pending registers
//   timeout_err one-cycle pulse when a grant times out
interface irq_bus_scheduler_if #(
   parameter int unsigned NCH = 9
);
   logic [NCH-1:0] en;
   logic [NCH-1:0] req_a;
   logic [NCH-1:0] req_b;
   logic [NCH-1:0] req_c;
   logic           irq_ack;
   logic           irq_valid;
   logic [1:0]     irq_bus;
   logic [3:0]     irq_chan;
   logic [NCH-1:0] pend_a;
   logic [NCH-1:0] pend_b;
   logic [NCH-1:0] pend_c;
   logic           timeout_err;

   modport master (
      output en, req_a, req_b, req_c, irq_ack,
      input  irq_valid, irq_bus, irq_chan, pend_a, pend_b, pend_c, timeout_err
   );

   modport slave (
      input  en, req_a, req_b, req_c, irq_ack,
      output irq_valid, irq_bus, irq_chan, pend_a, pend_b, pend_c, timeout_err
   );
endinterface

// File: rtl/irq_bus_scheduler.sv
// irq_bus_scheduler
//   Latches request pulses from buses A/B/C, masks them with the shared
//   channel enable and grants one request at a time (A > B > C, lowest
//   channel first) under a valid/ack handshake with an ack timeout.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    irq_bus_scheduler_if.slave (requests in, grant/pending out)
module irq_bus_scheduler #(
   parameter int unsigned NCH         = 9,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input logic                clk,
   input logic                rst_n,
   irq_bus_scheduler_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t         r_state;
   logic [7:0]     r_timer;
   logic           r_valid;
   logic [1:0]     r_bus;
   logic [3:0]     r_chan;
   logic           r_timeout;
   logic [NCH-1:0] r_pend_a;
   logic [NCH-1:0] r_pend_b;
   logic [NCH-1:0] r_pend_c;

   logic [NCH-1:0] w_elig_a;
   logic [NCH-1:0] w_elig_b;
   logic [NCH-1:0] w_elig_c;
   logic           w_found;
   logic [1:0]     w_win_bus;
   logic [3:0]     w_win_chan;
   logic           w_accept;
   logic [NCH-1:0] w_onehot;
   logic [NCH-1:0] w_clr_a;
   logic [NCH-1:0] w_clr_b;
   logic [NCH-1:0] w_clr_c;

   assign w_elig_a = r_pend_a & bus.en;
   assign w_elig_b = r_pend_b & bus.en;
   assign w_elig_c = r_pend_c & bus.en;

   // Scan lowest priority first so that later hits override earlier ones:
   // the final winner is the highest bus, lowest channel.
   always_comb begin
      w_found    = 1'b0;
      w_win_bus  = 2'd0;
      w_win_chan = 4'd0;
      for (int unsigned i = NCH; i > 0; i--) begin
         if (w_elig_c[i-1]) begin
            w_found    = 1'b1;
            w_win_bus  = 2'd2;
            w_win_chan = 4'(i - 1);
         end
      end
      for (int unsigned i = NCH; i > 0; i--) begin
         if (w_elig_b[i-1]) begin
            w_found    = 1'b1;
            w_win_bus  = 2'd1;
            w_win_chan = 4'(i - 1);
         end
      end
      for (int unsigned i = NCH; i > 0; i--) begin
         if (w_elig_a[i-1]) begin
            w_found    = 1'b1;
            w_win_bus  = 2'd0;
            w_win_chan = 4'(i - 1);
         end
      end
   end

   assign w_accept = (r_state == ST_GRANT) && bus.irq_ack;

   always_comb begin
      w_onehot = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (r_chan == 4'(i)) w_onehot[i] = 1'b1;
      end
   end

   assign w_clr_a = (w_accept && r_bus == 2'd0) ? w_onehot : '0;
   assign w_clr_b = (w_accept && r_bus == 2'd1) ? w_onehot : '0;
   assign w_clr_c = (w_accept && r_bus == 2'd2) ? w_onehot : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_valid   <= 1'b0;
         r_bus     <= '0;
         r_chan    <= '0;
         r_timeout <= 1'b0;
         r_pend_a  <= '0;
         r_pend_b  <= '0;
         r_pend_c  <= '0;
      end else begin
         // Clear first, then OR in new requests: a same-cycle request survives the ack.
         r_pend_a  <= (r_pend_a & ~w_clr_a) | bus.req_a;
         r_pend_b  <= (r_pend_b & ~w_clr_b) | bus.req_b;
         r_pend_c  <= (r_pend_c & ~w_clr_c) | bus.req_c;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_valid <= 1'b1;
                  r_bus   <= w_win_bus;
                  r_chan  <= w_win_chan;
                  r_timer <= '0;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (bus.irq_ack) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_timer == 8'(ACK_TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_valid   <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.irq_valid   = r_valid;
   assign bus.irq_bus     = r_bus;
   assign bus.irq_chan    = r_chan;
   assign bus.timeout_err = r_timeout;
   assign bus.pend_a      = r_pend_a;
   assign bus.pend_b      = r_pend_b;
   assign bus.pend_c      = r_pend_c;

endmodule

// File: tb/tb_irq_bus_scheduler.sv
// tb_irq_bus_scheduler
//   Directed vector table, hand-written timeout/reset sequences and a
//   randomized phase, all compared against a cycle-level reference model.
module tb_irq_bus_scheduler;

   localparam int unsigned NCH = 9;
   localparam int unsigned TO  = 15;
   localparam logic [8:0]  E   = 9'h1FF;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   irq_bus_scheduler_if #(.NCH(NCH)) u_if ();

   irq_bus_scheduler #(.NCH(NCH), .ACK_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending flags per bus/channel, current grant and its age.
   bit m_pend[3][NCH];
   bit m_valid;
   int m_bus;
   int m_chan;
   int m_age;
   bit m_to;

   task automatic model_reset();
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < NCH; i++) m_pend[b][i] = 0;
      m_valid = 0; m_bus = 0; m_chan = 0; m_age = 0; m_to = 0;
   endtask

   task automatic model_step(input logic [8:0] en, input logic [8:0] ra,
                             input logic [8:0] rb, input logic [8:0] rc,
                             input logic ack);
      logic [8:0] req[3];
      bit         done;
      bit         acked;
      req[0] = ra; req[1] = rb; req[2] = rc;
      acked = m_valid && ack;
      m_to  = 0;
      if (m_valid) begin
         if (ack) m_valid = 0;
         else if (m_age == TO) begin m_valid = 0; m_to = 1; end
         else m_age++;
      end else begin
         done = 0;
         for (int b = 0; b < 3; b++)
            for (int i = 0; i < NCH; i++)
               if (!done && m_pend[b][i] && en[i]) begin
                  done = 1; m_valid = 1; m_bus = b; m_chan = i; m_age = 1;
               end
      end
      if (acked) m_pend[m_bus][m_chan] = 0;
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < NCH; i++)
            if (req[b][i]) m_pend[b][i] = 1;
   endtask

   function automatic logic [34:0] model_vec();
      logic [8:0] p[3];
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < NCH; i++) p[b][i] = m_pend[b][i];
      return {m_valid, 2'(m_bus), 4'(m_chan), p[0], p[1], p[2], m_to};
   endfunction

   function automatic logic [34:0] dut_vec();
      return {u_if.irq_valid, u_if.irq_bus, u_if.irq_chan,
              u_if.pend_a, u_if.pend_b, u_if.pend_c, u_if.timeout_err};
   endfunction

   task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, advance the model at the edge, compare 1ns later.
   task automatic cycle(input logic [8:0] en, input logic [8:0] ra, input logic [8:0] rb,
                        input logic [8:0] rc, input logic ack, input string name);
      @(negedge clk);
      u_if.en = en; u_if.req_a = ra; u_if.req_b = rb; u_if.req_c = rc; u_if.irq_ack = ack;
      @(posedge clk);
      model_step(en, ra, rb, rc, ack);
      #1;
      chk(name, dut_vec(), model_vec());
   endtask

   typedef struct {
      logic [8:0] en, ra, rb, rc;
      logic       ack;
      logic       v;
      logic [1:0] b;
      logic [3:0] c;
      logic [8:0] pa, pb, pc;
      logic       to;
   } vec_t;

   vec_t tbl[26];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      // Basic grant/ack, cross-bus priority, enable masking, set-wins on ack.
      tbl[0]  = '{E,     9'h000, 9'h010, 9'h000, 1'b0, 1'b0, 2'd0, 4'd0, 9'h000, 9'h010, 9'h000, 1'b0};
      tbl[1]  = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd1, 4'd4, 9'h000, 9'h010, 9'h000, 1'b0};
      tbl[2]  = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd1, 4'd4, 9'h000, 9'h000, 9'h000, 1'b0};
      tbl[3]  = '{E,     9'h080, 9'h001, 9'h001, 1'b0, 1'b0, 2'd1, 4'd4, 9'h080, 9'h001, 9'h001, 1'b0};
      tbl[4]  = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd0, 4'd7, 9'h080, 9'h001, 9'h001, 1'b0};
      tbl[5]  = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd0, 4'd7, 9'h000, 9'h001, 9'h001, 1'b0};
      tbl[6]  = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd1, 4'd0, 9'h000, 9'h001, 9'h001, 1'b0};
      tbl[7]  = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd1, 4'd0, 9'h000, 9'h000, 9'h001, 1'b0};
      tbl[8]  = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd2, 4'd0, 9'h000, 9'h000, 9'h001, 1'b0};
      tbl[9]  = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd2, 4'd0, 9'h000, 9'h000, 9'h000, 1'b0};
      tbl[10] = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'd2, 4'd0, 9'h000, 9'h000, 9'h000, 1'b0};
      tbl[11] = '{9'h0E0, 9'h0F0, 9'h000, 9'h000, 1'b0, 1'b0, 2'd2, 4'd0, 9'h0F0, 9'h000, 9'h000, 1'b0};
      tbl[12] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd0, 4'd5, 9'h0F0, 9'h000, 9'h000, 1'b0};
      tbl[13] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd0, 4'd5, 9'h0D0, 9'h000, 9'h000, 1'b0};
      tbl[14] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd0, 4'd6, 9'h0D0, 9'h000, 9'h000, 1'b0};
      tbl[15] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd0, 4'd6, 9'h090, 9'h000, 9'h000, 1'b0};
      tbl[16] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd0, 4'd7, 9'h090, 9'h000, 9'h000, 1'b0};
      tbl[17] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd0, 4'd7, 9'h010, 9'h000, 9'h000, 1'b0};
      tbl[18] = '{9'h0E0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'd0, 4'd7, 9'h010, 9'h000, 9'h000, 1'b0};
      tbl[19] = '{9'h1F0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd0, 4'd4, 9'h010, 9'h000, 9'h000, 1'b0};
      tbl[20] = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd0, 4'd4, 9'h000, 9'h000, 9'h000, 1'b0};
      tbl[21] = '{E,     9'h000, 9'h000, 9'h008, 1'b0, 1'b0, 2'd0, 4'd4, 9'h000, 9'h000, 9'h008, 1'b0};
      tbl[22] = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd2, 4'd3, 9'h000, 9'h000, 9'h008, 1'b0};
      tbl[23] = '{E,     9'h000, 9'h000, 9'h008, 1'b1, 1'b0, 2'd2, 4'd3, 9'h000, 9'h000, 9'h008, 1'b0};
      tbl[24] = '{E,     9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 2'd2, 4'd3, 9'h000, 9'h000, 9'h008, 1'b0};
      tbl[25] = '{E,     9'h000, 9'h000, 9'h000, 1'b1, 1'b0, 2'd2, 4'd3, 9'h000, 9'h000, 9'h000, 1'b0};

      u_if.en = E; u_if.req_a = '0; u_if.req_b = '0; u_if.req_c = '0; u_if.irq_ack = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", dut_vec(), 35'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 26; k++) begin
         cycle(tbl[k].en, tbl[k].ra, tbl[k].rb, tbl[k].rc, tbl[k].ack, $sformatf("tbl_model_%0d", k));
         chk($sformatf("tbl_%0d", k), dut_vec(),
             {tbl[k].v, tbl[k].b, tbl[k].c, tbl[k].pa, tbl[k].pb, tbl[k].pc, tbl[k].to});
      end

      // Timeout: A/2 never acked -> 15 grant cycles, one idle cycle with the pulse, regrant.
      cycle(E, 9'h004, 9'h000, 9'h000, 1'b0, "to_req");
      for (int g = 1; g <= TO; g++) begin
         cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "to_wait");
         chk($sformatf("to_grant_%0d", g), 35'({u_if.irq_valid, u_if.irq_bus, u_if.irq_chan, u_if.timeout_err}),
             35'({1'b1, 2'd0, 4'd2, 1'b0}));
      end
      cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "to_drop");
      chk("to_pulse", 35'({u_if.irq_valid, u_if.timeout_err, u_if.pend_a}), 35'({1'b0, 1'b1, 9'h004}));
      cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "to_regrant");
      chk("to_regrant_val", 35'({u_if.irq_valid, u_if.irq_chan, u_if.timeout_err}), 35'({1'b1, 4'd2, 1'b0}));

      // Ack on the final timer cycle wins over the timeout.
      for (int g = 1; g < TO; g++) cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "ackto_wait");
      cycle(E, 9'h000, 9'h000, 9'h000, 1'b1, "ackto_ack");
      chk("ackto_no_pulse", 35'({u_if.irq_valid, u_if.timeout_err, u_if.pend_a}), 35'({1'b0, 1'b0, 9'h000}));

      // Asynchronous reset in the middle of a grant.
      cycle(E, 9'h002, 9'h040, 9'h000, 1'b0, "rst_req");
      cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "rst_grant");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async", 35'({u_if.irq_valid, u_if.pend_a, u_if.pend_b, u_if.pend_c}), 35'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) cycle(E, 9'h000, 9'h000, 9'h000, 1'b0, "rst_quiet");
      chk("rst_no_grant", 35'(u_if.irq_valid), 35'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic [8:0] en, ra, rb, rc;
         logic       ack;
         en  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : E;
         ra  = ($urandom_range(0, 5) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'h000;
         rb  = ($urandom_range(0, 5) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'h000;
         rc  = ($urandom_range(0, 4) == 0) ? 9'($urandom) : 9'h000;
         ack = ($urandom_range(0, 7) == 0);
         cycle(en, ra, rb, rc, ack, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
